// File: rtl/trace_buffer.sv
// trace_buffer
//   Records the most recent 2**ADDR_W committed instructions of the core in a
//   circular buffer. A hold button freezes the core and lets the user step
//   backward and forward through the recorded trace on the hex display.
//
// Ports
//   clk, rst         system clock, asynchronous active-low reset
//   core_tick        one-cycle pulse per committed instruction
//   pc, wdata        pc and write-back data of the committing instruction
//   reg_write        RegWrite of the committing instruction
//   btn_hold/prev/next  raw active-high buttons, asynchronous to clk
//   core_stall       high while browsing; the core must not tick
//   disp_pc/data/we  entry shown on the display
//   disp_idx         age of the displayed entry (0 = newest)
//   count            number of valid entries, 0..DEPTH
//   empty            count == 0
//   lost             sticky; a commit arrived while browsing
module trace_buffer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_tick,
  input  logic [31:0]       pc,
  input  logic [31:0]       wdata,
  input  logic              reg_write,
  input  logic              btn_hold,
  input  logic              btn_prev,
  input  logic              btn_next,
  output logic              core_stall,
  output logic [31:0]       disp_pc,
  output logic [31:0]       disp_data,
  output logic              disp_we,
  output logic [ADDR_W-1:0] disp_idx,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              lost
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic {
    RUN    = 1'b0,
    BROWSE = 1'b1
  } state_t;

  state_t state, next_state;

  logic [64:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [64:0]       rd_entry;

  logic [2:0] hold_sr, prev_sr, next_sr;
  logic       hold_evt, prev_evt, next_evt;
  logic       can_older, can_newer;

  // Two synchroniser flops followed by an edge-detect flop per button;
  // the event is the rising edge seen between stages 1 and 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_sr <= '0;
      prev_sr <= '0;
      next_sr <= '0;
    end else begin
      hold_sr <= {hold_sr[1:0], btn_hold};
      prev_sr <= {prev_sr[1:0], btn_prev};
      next_sr <= {next_sr[1:0], btn_next};
    end
  end

  assign hold_evt = hold_sr[1] & ~hold_sr[2];
  assign prev_evt = prev_sr[1] & ~prev_sr[2];
  assign next_evt = next_sr[1] & ~next_sr[2];

  // Newest entry sits just behind the write pointer; idx counts backwards.
  assign rd_addr  = wr_ptr - PTR_ONE - idx;
  assign rd_entry = mem[rd_addr];

  assign can_older = (count != '0) && (({1'b0, idx} + CNT_ONE) < count);
  assign can_newer = (idx != '0);

  assign empty = (count == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // A hold event toggles between recording and browsing.
  always_comb begin
    next_state = state;
    if (hold_evt) begin
      next_state = (state == RUN) ? BROWSE : RUN;
    end
  end

  // Trace storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (state == RUN && core_tick) begin
      mem[wr_ptr] <= {reg_write, wdata, pc};
    end
  end

  // Pointers, counters, stall and display registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      core_stall <= 1'b0;
      lost       <= 1'b0;
      disp_pc    <= '0;
      disp_data  <= '0;
      disp_we    <= 1'b0;
      disp_idx   <= '0;
    end else if (state == RUN) begin
      if (core_tick) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (count != CNT_FULL) begin
          count <= count + CNT_ONE;
        end
      end
      disp_pc    <= pc;
      disp_data  <= wdata;
      disp_we    <= reg_write;
      disp_idx   <= '0;
      idx        <= '0;
      core_stall <= hold_evt;
    end else begin
      if (core_tick) begin
        lost <= 1'b1;
      end

      // Hold takes priority over any step requested in the same cycle.
      if (hold_evt) begin
        count      <= '0;
        wr_ptr     <= '0;
        idx        <= '0;
        core_stall <= 1'b0;
        lost       <= 1'b0;
      end else if (prev_evt && !next_evt && can_older) begin
        idx <= idx + PTR_ONE;
      end else if (next_evt && !prev_evt && can_newer) begin
        idx <= idx - PTR_ONE;
      end

      if (count == '0) begin
        disp_pc   <= '0;
        disp_data <= '0;
        disp_we   <= 1'b0;
      end else begin
        disp_pc   <= rd_entry[31:0];
        disp_data <= rd_entry[63:32];
        disp_we   <= rd_entry[64];
      end
      disp_idx <= idx;
    end
  end

endmodule
